signal_creater_n: RTL
=====================

SIGNAL_CREATER_N -- requirements
Module: signal_creater_n

Interface
REQ-001 Parameter WIDTH, default 8, gives the pattern length in bits; legal range is 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH), gives the bit-index width; it is derived and not overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port load, input, 1 bit: start/reload request; acts only on its sampled 0->1 transition.
REQ-006 Port D, input, WIDTH bits: parallel pattern, captured at load.
REQ-007 Port mode, input, 1 bit: captured at load; 0 = cyclic repeat, 1 = one-shot.
REQ-008 Port lsb_first, input, 1 bit: captured at load; 1 = D[0] first, 0 = D[WIDTH-1] first.
REQ-009 Port stop, input, 1 bit: abort request.
REQ-010 Port out, output, 1 bit: registered serial pattern output.
REQ-011 Port busy, output, 1 bit: high while in RUN.
REQ-012 Port done, output, 1 bit: one-cycle registered pulse at end of pattern.
REQ-013 Port bit_idx, output, CW bits: index (0..WIDTH-1) of the bit currently on out.

Function
REQ-014 The block SHALL use two states, IDLE and RUN; reset enters IDLE.
REQ-015 A load request SHALL be load=1 at an edge where the previously sampled load was 0; holding load high starts exactly once.
REQ-016 At the request edge, the block SHALL capture D, mode and lsb_first, enter RUN, set bit_idx=0 and drive out with the first pattern bit, giving zero-cycle latency to the first bit.
REQ-017 In RUN, each following edge SHALL advance bit_idx by 1 and drive out with the corresponding bit in the captured order.
REQ-018 In cyclic mode, after bit_idx=WIDTH-1 the next edge SHALL wrap bit_idx to 0, resend the first bit, remain in RUN and pulse done for that one cycle.
REQ-019 In one-shot mode, after bit_idx=WIDTH-1 the next edge SHALL enter IDLE, set out=0, busy=0 and bit_idx=0, and pulse done for that one cycle.
REQ-020 A load request during RUN SHALL restart the pattern from bit 0 with the newly captured values, and SHALL NOT pulse done on that edge.
REQ-021 A load request on the wrap/end edge SHALL take priority over the wrap, restart the pattern, and leave done=0.
REQ-022 stop=1 at any edge SHALL force IDLE with out=0, bit_idx=0 and done=0; stop outranks a simultaneous load request.
REQ-023 In IDLE, out, busy and done SHALL be 0; changes on D, mode and lsb_first SHALL have no effect outside a load request.
REQ-024 Priority order SHALL be: reset > stop > load request > normal advance.

Reset
REQ-025 With rst_n=0 at an edge, out, busy, done and bit_idx SHALL be 0, the pattern register SHALL be 0, the state SHALL be IDLE, and the load-edge history SHALL be 0.
REQ-026 A reset in the middle of RUN SHALL abort on that edge without a done pulse.
REQ-027 If load is held high through the release of rst_n, the block SHALL count it as a request on the first edge after release.

Structure
REQ-028 Package signal_creater_pkg SHALL hold the state typedef (IDLE, RUN) and the mode constants MODE_CYCLIC=0 and MODE_ONESHOT=1.
REQ-029 Sub-module sc_bit_counter SHALL implement the wrap-at-WIDTH-1 index counter with clear and enable inputs; all other logic stays in signal_creater_n.

Verification
REQ-030 WIDTH=4, D=4'b1001, mode=0, lsb_first=0, load held high -> out=1,0,0,1 repeating; done high on each bit_idx 3->0 edge; no re-trigger from the held load.
REQ-031 WIDTH=4, D=4'b0011, mode=1, lsb_first=1, load pulsed -> out=1,1,0,0, then 0; busy falls together with a single-cycle done.
REQ-032 WIDTH=8, D=8'hA5 cyclic; at bit_idx=3 apply a load request with D=8'hFF -> the next out=1 with bit_idx=0, and no done pulse.
REQ-033 Cyclic run; stop and a load request on the same edge -> IDLE, out=0, busy=0, done=0.
REQ-034 One-shot run; rst_n=0 at bit_idx=2 -> all outputs 0 on that edge and no done pulse; load held high across the release starts a new run.
REQ-035 WIDTH=4 one-shot; a load request on the bit_idx=3 edge -> pattern restarts at bit 0, done stays 0, busy stays 1.

Source files
------------

// File: rtl/signal_creater_pkg.sv
// Shared types and constants for the serial pattern generator.
// Imported by signal_creater_n and sc_bit_counter.
package signal_creater_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_CYCLIC  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/sc_bit_counter.sv
// Bit-position counter: counts 0..WIDTH-1 and wraps to 0.
// Clear outranks enable; last_o flags the final position.
module sc_bit_counter
    import signal_creater_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] idx_o,
    output logic          last_o
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/signal_creater_n.sv
// Serial pattern generator: shifts a captured WIDTH-bit pattern out on 'out',
// cyclic or one-shot, in either bit order. First bit appears on the load edge.
module signal_creater_n
    import signal_creater_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             mode,
    input  logic             lsb_first,
    input  logic             stop,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_idx
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             mode_q, mode_d;
    logic             lsb_q, lsb_d;
    logic             load_q;
    logic             out_q, out_d;
    logic             done_q, done_d;

    logic             load_req;
    logic [WIDTH-1:0] ord_pat;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    idx_nxt;
    logic             idx_last;
    logic             cnt_clr;
    logic             cnt_en;

    assign load_req = load & ~load_q;

    // ord_pat[i] is the bit to transmit at position i in the captured order.
    always_comb begin
        ord_pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ord_pat[i] = lsb_q ? pat_q[i] : pat_q[WIDTH-1-i];
        end
    end

    assign idx_nxt = idx + CW'(1);
    assign cnt_clr = stop | load_req;
    assign cnt_en  = (state_q == RUN);

    sc_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    // Priority: stop > load request > normal advance; reset handled in always_ff.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        mode_d  = mode_q;
        lsb_d   = lsb_q;
        out_d   = 1'b0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (load_req) begin
            state_d = RUN;
            pat_d   = D;
            mode_d  = mode;
            lsb_d   = lsb_first;
            out_d   = lsb_first ? D[0] : D[WIDTH-1];
        end else if (state_q == RUN) begin
            if (idx_last) begin
                done_d = 1'b1;
                if (mode_q == MODE_CYCLIC) begin
                    out_d = ord_pat[0];
                end else begin
                    state_d = IDLE;
                end
            end else begin
                out_d = ord_pat[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            mode_q  <= MODE_CYCLIC;
            lsb_q   <= 1'b0;
            load_q  <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
            lsb_q   <= lsb_d;
            load_q  <= load;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out     = out_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign bit_idx = idx;

endmodule
